// File: rtl/display7_scan.sv
`default_nettype none
// ============================================================================
// Module   : display7_scan
// Purpose  : Time-multiplexed scan controller for a bank of common-anode
//            7-segment digits that share one display7 decoder. Rotates one
//            digit per slot and blanks all anodes briefly at the start of
//            each slot to suppress ghosting. New values are staged and only
//            committed at frame boundaries, so a displayed frame never tears.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DIGITS  number of digits scanned (>= 2)
//   DIV     clock cycles per digit slot (> BLANK)
//   BLANK   leading cycles of each slot with all anodes off (0 = none)
// Ports:
//   iClk      in   1          system clock, rising edge
//   iRst_n    in   1          asynchronous reset, active-low
//   iValue    in   4*DIGITS   hex digits, digit k = iValue[4k+3:4k]
//   iLoad     in   1          one-cycle strobe, stages iValue
//   iEnMask   in   DIGITS     per-digit enable, 1 = digit may light
//   oNibble   out  4          nibble of current digit, to decoder input
//   oAn       out  DIGITS     anode selects, active-low, at most one low
//   oPending  out  1          staged value not yet committed
//   oFrame    out  1          one-cycle pulse after the scan wraps to digit 0
// Build option:
//   DISPLAY7_SCAN_LZB_EN  leading-zero blanking of the upper digits
// ============================================================================
module display7_scan #(
  parameter int DIGITS = 8,
  parameter int DIV    = 100000,
  parameter int BLANK  = 4
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [4*DIGITS-1:0]   iValue,
  input  logic                  iLoad,
  input  logic [DIGITS-1:0]     iEnMask,
  output logic [3:0]            oNibble,
  output logic [DIGITS-1:0]     oAn,
  output logic                  oPending,
  output logic                  oFrame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  localparam logic [CW-1:0] C_CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] C_BLANK_LAST = (BLANK > 0) ? CW'(BLANK - 1) : '0;
  localparam logic [IW-1:0] C_IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } stateT;

  // With no blanking interval the slot starts directly in SHOW.
  localparam stateT C_START_STATE = (BLANK > 0) ? ST_BLANK : ST_SHOW;

  stateT                 rState;
  logic [CW-1:0]         rCnt;
  logic [IW-1:0]         rIdx;
  logic [4*DIGITS-1:0]   rDisp;
  logic [4*DIGITS-1:0]   rStage;

  logic                  wSlotEnd;
  logic                  wWrap;
  logic [DIGITS-1:0]     wSuppress;
  logic [3:0]            wNibble;
  logic [DIGITS-1:0]     wAn;

  assign wSlotEnd = (rCnt == C_CNT_LAST);
  assign wWrap    = wSlotEnd && (rIdx == C_IDX_LAST);

`ifdef DISPLAY7_SCAN_LZB_EN
  // wZeroFrom[k] is set when digits k..DIGITS-1 of the display are all zero.
  logic [DIGITS:0] wZeroFrom;
  assign wZeroFrom[DIGITS] = 1'b1;
  for (genvar k = 0; k < DIGITS; k++) begin : g_lzb
    assign wZeroFrom[k] = wZeroFrom[k+1] && (rDisp[4*k +: 4] == 4'h0);
    // Digit 0 always shows, so a zero value still reads "0".
    assign wSuppress[k] = (k > 0) && wZeroFrom[k];
  end
`else
  assign wSuppress = '0;
`endif

  // Select the current digit's nibble and its anode; anode only drops in SHOW.
  always_comb begin
    wNibble = 4'h0;
    wAn     = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (rIdx == IW'(k)) begin
        wNibble = rDisp[4*k +: 4];
        if ((rState == ST_SHOW) && iEnMask[k] && !wSuppress[k]) begin
          wAn[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rState   <= C_START_STATE;
      rCnt     <= '0;
      rIdx     <= '0;
      rDisp    <= '0;
      rStage   <= '0;
      oPending <= 1'b0;
      oFrame   <= 1'b0;
      oNibble  <= 4'h0;
      oAn      <= '1;
    end else begin
      // Slot counter and digit index.
      if (wSlotEnd) begin
        rCnt <= '0;
        rIdx <= (rIdx == C_IDX_LAST) ? '0 : rIdx + 1'b1;
      end else begin
        rCnt <= rCnt + 1'b1;
      end

      // Per-slot state machine.
      case (rState)
        ST_BLANK: if (rCnt == C_BLANK_LAST) rState <= ST_SHOW;
        ST_SHOW:  if (wSlotEnd && (BLANK > 0)) rState <= ST_BLANK;
        default:  rState <= C_START_STATE;
      endcase

      // Commit the staged value at the wrap. A load on the wrap cycle still
      // commits the previous stage; the new value waits one more frame.
      if (wWrap && oPending) begin
        rDisp <= rStage;
      end
      if (iLoad) begin
        rStage   <= iValue;
        oPending <= 1'b1;
      end else if (wWrap) begin
        oPending <= 1'b0;
      end

      // Registered outputs, one clock behind (state, idx).
      oFrame  <= wWrap;
      oNibble <= wNibble;
      oAn     <= wAn;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display7_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_display7_scan
// Purpose  : Self-checking bench for display7_scan (DIGITS=4, DIV=8, BLANK=2).
//            A behavioural model predicts each cycle's outputs from the slot
//            position counted since reset; predictions go through a
//            scoreboard queue and are compared after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display7_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIV * DIGITS;

  logic        iClk    = 1'b0;
  logic        iRst_n  = 1'b1;
  logic [15:0] iValue  = 16'h0;
  logic        iLoad   = 1'b0;
  logic [3:0]  iEnMask = 4'hF;
  logic [3:0]  oNibble;
  logic [3:0]  oAn;
  logic        oPending;
  logic        oFrame;

  display7_scan #(
    .DIGITS (DIGITS),
    .DIV    (DIV),
    .BLANK  (BLANK)
  ) dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iValue   (iValue),
    .iLoad    (iLoad),
    .iEnMask  (iEnMask),
    .oNibble  (oNibble),
    .oAn      (oAn),
    .oPending (oPending),
    .oFrame   (oFrame)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] nib;
    logic       pend;
    logic       frame;
  } expT;

  expT sb[$];

  int tests = 0;
  int fails = 0;

  // Model state: pos counts clock edges since reset release.
  int          pos   = 0;
  logic [15:0] mDisp = 16'h0;
  logic [15:0] mStage = 16'h0;
  logic        mPend = 1'b0;

  function automatic logic [3:0] expAn(int p, logic [3:0] mask, logic [15:0] disp);
    int         slot;
    int         dig;
    logic [3:0] an;
    logic       lit;
    slot = p % DIV;
    dig  = (p / DIV) % DIGITS;
    an   = 4'hF;
    lit  = (slot >= BLANK) && mask[dig];
`ifdef DISPLAY7_SCAN_LZB_EN
    if ((dig > 0) && ((disp >> (4 * dig)) == 16'h0)) lit = 1'b0;
`endif
    if (lit) an[dig] = 1'b0;
    return an;
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (pos %0d)", tag, got, exp, pos);
    end
  endtask

  task automatic step(input logic load, input logic [15:0] val);
    expT  e;
    expT  got;
    logic wrap;
    int   dig;
    @(negedge iClk);
    iLoad  = load;
    iValue = val;
    wrap   = (pos % FRAME) == (FRAME - 1);
    dig    = (pos / DIV) % DIGITS;
    e.an    = expAn(pos, iEnMask, mDisp);
    e.nib   = 4'((mDisp >> (4 * dig)) & 16'hF);
    e.pend  = load ? 1'b1 : (wrap ? 1'b0 : mPend);
    e.frame = wrap;
    sb.push_back(e);
    @(posedge iClk);
    #1;
    iLoad = 1'b0;
    got = sb.pop_front();
    check("oAn",      oAn,            got.an);
    check("oNibble",  oNibble,        got.nib);
    check("oPending", {3'b0, oPending}, {3'b0, got.pend});
    check("oFrame",   {3'b0, oFrame},   {3'b0, got.frame});
    if (wrap && mPend) mDisp = mStage;
    if (load) mStage = val;
    mPend = got.pend;
    pos++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0);
  endtask

  task automatic modelReset();
    pos    = 0;
    mDisp  = 16'h0;
    mStage = 16'h0;
    mPend  = 1'b0;
  endtask

  task automatic checkResetState();
    check("rst_oAn",      oAn,              4'hF);
    check("rst_oNibble",  oNibble,          4'h0);
    check("rst_oPending", {3'b0, oPending}, 4'h0);
    check("rst_oFrame",   {3'b0, oFrame},   4'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset asserted between clock edges: outputs must clear without a clock.
    #1 iRst_n = 1'b0;
    #2 checkResetState();
    @(posedge iClk);
    #2 iRst_n = 1'b1;
    modelReset();

    // Plain scan with all digits enabled, through the first frame pulse.
    run(40);

    // Stage 1234 during the idx=1 slot, then show it for a full frame.
    step(1'b1, 16'h1234);
    run(55);

    // Only digits 0 and 2 enabled.
    iEnMask = 4'b0101;
    run(32);
    iEnMask = 4'hF;

    // Stage 5678, then load ABCD exactly on the wrap cycle.
    step(1'b1, 16'h5678);
    run(30);
    step(1'b1, 16'hABCD);
    run(64);

    // Reach SHOW of digit 2, then reset mid-slot.
    run(21);
    check("pre_rst_oAn", oAn, 4'b1011);
    #2 iRst_n = 1'b0;
    #1 checkResetState();
    @(posedge iClk);
    #2 iRst_n = 1'b1;
    modelReset();
    run(40);

`ifdef DISPLAY7_SCAN_LZB_EN
    step(1'b1, 16'h0050);
    run(63);
    step(1'b1, 16'h0000);
    run(63);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
